adc_xy_line_gen: RTL and testbench

// - Vector line source that emits one x/y/colour sample per enabled cycle, in the same format the ADC pins present.
// - Walks Bresenham segments between vertices pushed over a valid/ready interface.
// - Sits directly upstream of the adc_xy -> gfx -> vga fade/stripe pipeline; it replaces the raster counter stimulus.
// - Usable on-chip as a demo pattern source, or in benches.

---
 rtl/adc_xy_line_pkg.sv | 20 ++
 rtl/adc_xy_line_gen_bresenham_step.sv | 48 ++++
 rtl/adc_xy_line_gen.sv | 128 ++++++++++++
 tb/tb_adc_xy_line_gen.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/adc_xy_line_pkg.sv
// Shared types for the vector line source.
// Vertex bundle, FSM state codes and arithmetic widths.
package adc_xy_line_pkg;

   localparam int COORD_BITS = 10;
   localparam int ERR_BITS   = COORD_BITS + 2;

   typedef logic [0:0] state_t;

   localparam state_t IDLE = 1'b0;
   localparam state_t DRAW = 1'b1;

   typedef struct packed {
      logic [COORD_BITS-1:0] x;
      logic [COORD_BITS-1:0] y;
      logic                  move;
      logic [2:0]            color;
   } vertex_t;

endpackage

// File: rtl/adc_xy_line_gen_bresenham_step.sv
// One Bresenham step: advance the pen by at most one
// unit in x and y, update the error term, flag the end.
module bresenham_step #(
   parameter int DATA_BITS = 10
) (
   input  logic [DATA_BITS-1:0]        x,
   input  logic [DATA_BITS-1:0]        y,
   input  logic [DATA_BITS-1:0]        x_end,
   input  logic [DATA_BITS-1:0]        y_end,
   input  logic signed [DATA_BITS+1:0] err,
   input  logic signed [DATA_BITS+1:0] dx,
   input  logic signed [DATA_BITS+1:0] dy,
   input  logic                        sx,
   input  logic                        sy,
   output logic [DATA_BITS-1:0]        x_next,
   output logic [DATA_BITS-1:0]        y_next,
   output logic signed [DATA_BITS+1:0] err_next,
   output logic                        at_end
);

   localparam logic [DATA_BITS-1:0] ONE = DATA_BITS'(1);

   logic signed [DATA_BITS+2:0] e2;
   logic                        step_x;
   logic                        step_y;

   assign e2     = {err, 1'b0};
   assign step_x = (e2 >= dy);
   assign step_y = (e2 <= dx);

   // Apply the x and y adjustments independently; both may fire.
   always_comb begin
      err_next = err;
      x_next   = x;
      y_next   = y;
      if (step_x) begin
         err_next = err_next + dy;
         x_next   = sx ? x - ONE : x + ONE;
      end
      if (step_y) begin
         err_next = err_next + dx;
         y_next   = sy ? y - ONE : y + ONE;
      end
   end

   assign at_end = (x_next == x_end) && (y_next == y_end);

endmodule

// File: rtl/adc_xy_line_gen.sv
// Vector line source: walks Bresenham segments between
// pushed vertices, one x/y/colour sample per enabled cycle.
module adc_xy_line_gen
   import adc_xy_line_pkg::*;
#(
   parameter int DATA_BITS = COORD_BITS
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 v_valid,
   output logic                 v_ready,
   input  logic [DATA_BITS-1:0] v_x,
   input  logic [DATA_BITS-1:0] v_y,
   input  logic                 v_move,
   input  logic [2:0]           v_color,
   output logic [DATA_BITS-1:0] x,
   output logic [DATA_BITS-1:0] y,
   output logic                 red,
   output logic                 grn,
   output logic                 blu,
   output logic                 busy
);

   state_t                      state;
   vertex_t                     vin;
   logic [DATA_BITS-1:0]        x_end;
   logic [DATA_BITS-1:0]        y_end;
   logic signed [DATA_BITS+1:0] err;
   logic signed [DATA_BITS+1:0] dx;
   logic signed [DATA_BITS+1:0] dy;
   logic                        sx;
   logic                        sy;
   logic [2:0]                  color;

   logic [DATA_BITS-1:0]        dx_abs;
   logic [DATA_BITS-1:0]        dy_abs;
   logic signed [DATA_BITS+1:0] dx_new;
   logic signed [DATA_BITS+1:0] dy_new;
   logic [DATA_BITS-1:0]        x_next;
   logic [DATA_BITS-1:0]        y_next;
   logic signed [DATA_BITS+1:0] err_next;
   logic                        at_end;

   assign vin = '{x: v_x, y: v_y, move: v_move, color: v_color};

   assign v_ready = (state == IDLE) && enable && !reset;
   assign busy    = (state == DRAW);

   // Segment set-up terms from the current pen position.
   always_comb begin
      dx_abs = (vin.x >= x) ? vin.x - x : x - vin.x;
      dy_abs = (vin.y >= y) ? vin.y - y : y - vin.y;
      dx_new = $signed({2'b00, dx_abs});
      dy_new = -$signed({2'b00, dy_abs});
   end

   bresenham_step #(.DATA_BITS(DATA_BITS)) u_step (
      .x        (x),
      .y        (y),
      .x_end    (x_end),
      .y_end    (y_end),
      .err      (err),
      .dx       (dx),
      .dy       (dy),
      .sx       (sx),
      .sy       (sy),
      .x_next   (x_next),
      .y_next   (y_next),
      .err_next (err_next),
      .at_end   (at_end)
   );

   // FSM, pen position and sample registers; all hold while enable is low.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         x     <= '0;
         y     <= '0;
         red   <= 1'b0;
         grn   <= 1'b0;
         blu   <= 1'b0;
         x_end <= '0;
         y_end <= '0;
         err   <= '0;
         dx    <= '0;
         dy    <= '0;
         sx    <= 1'b0;
         sy    <= 1'b0;
         color <= '0;
      end else if (enable) begin
         unique case (state)
            IDLE: begin
               {red, grn, blu} <= 3'b000;
               if (v_valid) begin
                  if (vin.move) begin
                     x <= vin.x;
                     y <= vin.y;
                  end else if (vin.x == x && vin.y == y) begin
                     {red, grn, blu} <= vin.color;
                  end else begin
                     x_end <= vin.x;
                     y_end <= vin.y;
                     dx    <= dx_new;
                     dy    <= dy_new;
                     err   <= dx_new + dy_new;
                     sx    <= (vin.x < x);
                     sy    <= (vin.y < y);
                     color <= vin.color;
                     state <= DRAW;
                  end
               end
            end
            DRAW: begin
               x   <= x_next;
               y   <= y_next;
               err <= err_next;
               {red, grn, blu} <= color;
               if (at_end) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_adc_xy_line_gen.sv
// Directed bench for adc_xy_line_gen.
// Samples #1 after each rising edge; drives inputs at the same point.
module tb_adc_xy_line_gen;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic       v_valid;
   logic       v_ready;
   logic [9:0] v_x;
   logic [9:0] v_y;
   logic       v_move;
   logic [2:0] v_color;
   logic [9:0] x;
   logic [9:0] y;
   logic       red;
   logic       grn;
   logic       blu;
   logic       busy;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   adc_xy_line_gen dut (
      .clk     (clk),
      .reset   (reset),
      .enable  (enable),
      .v_valid (v_valid),
      .v_ready (v_ready),
      .v_x     (v_x),
      .v_y     (v_y),
      .v_move  (v_move),
      .v_color (v_color),
      .x       (x),
      .y       (y),
      .red     (red),
      .grn     (grn),
      .blu     (blu),
      .busy    (busy)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      assert (got === exp)
      else begin
         bad++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic chk_out(input string tag, input int ex, input int ey,
                          input int ec, input int eb);
      chk({tag, ".x"}, int'(x), ex);
      chk({tag, ".y"}, int'(y), ey);
      chk({tag, ".col"}, int'({red, grn, blu}), ec);
      chk({tag, ".busy"}, int'(busy), eb);
   endtask

   task automatic push(input int px, input int py, input bit mv,
                       input int col);
      v_valid = 1'b1;
      v_x     = 10'(px);
      v_y     = 10'(py);
      v_move  = mv;
      v_color = 3'(col);
      cyc();
      v_valid = 1'b0;
   endtask

   int xs27 [7] = '{0, 1, 1, 1, 1, 2, 2};

   initial begin
      reset   = 1'b1;
      enable  = 1'b1;
      v_valid = 1'b0;
      v_x     = '0;
      v_y     = '0;
      v_move  = 1'b0;
      v_color = '0;

      // reset held 5 cycles
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk_out("rst", 0, 0, 0, 0);
         chk("rst.ready", int'(v_ready), 0);
      end
      reset = 1'b0;
      #1;
      chk("idle.ready", int'(v_ready), 1);

      // (0,0) -> (5,0), white
      push(5, 0, 1'b0, 7);
      chk_out("h.acc", 0, 0, 0, 1);
      for (int i = 1; i <= 5; i++) begin
         cyc();
         chk_out("h.pt", i, 0, 7, (i < 5) ? 1 : 0);
      end
      cyc();
      chk_out("h.idle", 5, 0, 0, 0);

      // back to origin, then (0,0) -> (2,7)
      push(0, 0, 1'b1, 7);
      chk_out("mv0", 0, 0, 0, 0);
      push(2, 7, 1'b0, 2);
      chk_out("s.acc", 0, 0, 0, 1);
      for (int i = 0; i < 7; i++) begin
         cyc();
         chk_out("s.pt", xs27[i], i + 1, 2, (i < 6) ? 1 : 0);
      end

      // move (100,200) then diagonal to (97,203)
      push(100, 200, 1'b1, 7);
      chk_out("mv", 100, 200, 0, 0);
      push(97, 203, 1'b0, 4);
      chk_out("d.acc", 100, 200, 0, 1);
      for (int i = 1; i <= 3; i++) begin
         cyc();
         chk_out("d.pt", 100 - i, 200 + i, 4, (i < 3) ? 1 : 0);
      end

      // (97,203) -> (107,203) with a 4-cycle enable drop
      push(107, 203, 1'b0, 1);
      chk_out("e.acc", 97, 203, 0, 1);
      for (int i = 1; i <= 3; i++) begin
         cyc();
         chk_out("e.pt", 97 + i, 203, 1, 1);
      end
      enable = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk_out("e.hold", 100, 203, 1, 1);
         chk("e.hold.ready", int'(v_ready), 0);
      end
      enable = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         cyc();
         chk_out("e.res", 100 + i, 203, 1, (i < 7) ? 1 : 0);
      end

      // enable low in IDLE: no accept, outputs hold
      enable  = 1'b0;
      v_valid = 1'b1;
      v_x     = 10'd5;
      v_y     = 10'd5;
      v_move  = 1'b1;
      #1;
      chk("off.ready", int'(v_ready), 0);
      cyc();
      chk_out("off", 107, 203, 1, 0);
      v_valid = 1'b0;
      enable  = 1'b1;
      cyc();
      chk_out("off.idle", 107, 203, 0, 0);

      // draw to current position: single sample in colour
      push(107, 203, 1'b0, 6);
      chk_out("same", 107, 203, 6, 0);
      cyc();
      chk_out("same.idle", 107, 203, 0, 0);

      // full-scale diagonal, reset at sample 500
      push(0, 0, 1'b1, 0);
      chk_out("fs.mv", 0, 0, 0, 0);
      push(1023, 1023, 1'b0, 7);
      chk_out("fs.acc", 0, 0, 0, 1);
      for (int i = 1; i <= 500; i++) begin
         cyc();
         chk_out("fs.pt", i, i, 7, 1);
      end
      reset = 1'b1;
      cyc();
      chk_out("fs.rst", 0, 0, 0, 0);
      chk("fs.rst.ready", int'(v_ready), 0);
      reset = 1'b0;
      #1;
      chk("fs.ready", int'(v_ready), 1);
      push(0, 3, 1'b0, 2);
      chk_out("n.acc", 0, 0, 0, 1);
      for (int i = 1; i <= 3; i++) begin
         cyc();
         chk_out("n.pt", 0, i, 2, (i < 3) ? 1 : 0);
      end
      cyc();
      chk_out("n.idle", 0, 3, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
